// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and the master FSM state encoding.
package axi_lite_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] data_t;
    typedef logic [AXI_STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]                resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } mst_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a start_write/start_read command
// into AW/W/B or AR/R traffic and reports the response and read data.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  start_write,
    input  logic                  start_read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output resp_t                 resp,
    output logic [DATA_WIDTH-1:0] rd_data,
    axi_lite_if.master            m
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    mst_state_t            state_q,   state_d;
    logic                  pend_rd_q, pend_rd_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    resp_t                 resp_q,    resp_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  bready_q,  bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q,  rready_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Channel handshakes as seen at the coming edge.
    assign aw_hs = awvalid_q && m.awready;
    assign w_hs  = wvalid_q  && m.wready;
    assign b_hs  = bready_q  && m.bvalid;
    assign ar_hs = arvalid_q && m.arready;
    assign r_hs  = rready_q  && m.rvalid;

    // Next-state and next-output logic; every output is computed one edge ahead.
    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        rd_data_d = rd_data_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_write) begin
                    // A simultaneous read is remembered and issued after the write.
                    awaddr_d  = addr;
                    wdata_d   = data;
                    wstrb_d   = {STRB_WIDTH{1'b1}};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR;
                    if (start_read) begin
                        araddr_d  = addr;
                        pend_rd_d = 1'b1;
                    end
                end else if (start_read) begin
                    araddr_d  = addr;
                    arvalid_d = 1'b1;
                    state_d   = ST_RD_ADDR;
                end
            end
            ST_WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    resp_d   = m.bresp;
                    done_d   = 1'b1;
                    bready_d = 1'b0;
                    if (pend_rd_q) begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    rd_data_d = m.rdata;
                    resp_d    = m.rresp;
                    done_d    = 1'b1;
                    rready_d  = 1'b0;
                    pend_rd_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= ST_IDLE;
            pend_rd_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= RESP_OKAY;
            rd_data_q <= '0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            rd_data_q <= rd_data_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resp      = resp_q;
    assign rd_data   = rd_data_q;
    assign m.awaddr  = awaddr_q;
    assign m.awvalid = awvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.wvalid  = wvalid_q;
    assign m.bready  = bready_q;
    assign m.araddr  = araddr_q;
    assign m.arvalid = arvalid_q;
    assign m.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a transaction-queue model of the
// master, a delay-programmable slave, directed scenarios and a random phase.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          start_write = 1'b0;
    logic          start_read = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic          busy, done;
    logic [1:0]    resp;
    logic [DW-1:0] rd_data;

    axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk        (clk),
        .areset_n    (areset_n),
        .start_write (start_write),
        .start_read  (start_read),
        .addr        (addr),
        .data        (data),
        .busy        (busy),
        .done        (done),
        .resp        (resp),
        .rd_data     (rd_data),
        .m           (bus)
    );

    always #5 clk = ~clk;

    // Model: queue of accepted-but-uncompleted transactions, front is active.
    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        q[$];
    bit          aw_seen, w_seen, ar_seen;
    bit          exp_done;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Values sampled just before each rising edge.
    bit          s_sw, s_sr, s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
    logic [31:0] s_addr, s_data, s_rdata, s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    // Slave knobs and counters.
    bit          rand_mode = 1'b0;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [1:0]  bresp_k, rresp_k;
    logic [31:0] rdata_k;

    // Observations for the directed literal checks.
    int          done_cnt, ar_hs_cnt, awv_cycles, wv_cycles, arv_cycles;
    int          start_cyc, done_cyc;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    task automatic clear_model();
        q.delete();
        aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
        exp_done = 1'b0; exp_resp = 2'b00; exp_rd = '0;
    endtask

    task automatic step_model();
        bit busy_pre;
        busy_pre = (q.size() != 0);
        exp_done = 1'b0;
        if (s_aw_hs) begin aw_seen = 1'b1; cap_awaddr = s_awaddr; end
        if (s_w_hs)  begin w_seen = 1'b1; cap_wdata = s_wdata; cap_wstrb = s_wstrb; end
        if (s_ar_hs) begin ar_seen = 1'b1; cap_araddr = s_araddr; ar_hs_cnt++; end
        if (s_b_hs || s_r_hs) begin
            if (q.size() != 0) void'(q.pop_front());
            aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
            exp_done = 1'b1;
            exp_resp = s_b_hs ? s_bresp : s_rresp;
            if (s_r_hs) exp_rd = s_rdata;
        end
        if (!busy_pre && (s_sw || s_sr)) begin
            start_cyc = cyc;
            if (s_sw) q.push_back('{is_rd: 1'b0, addr: s_addr, data: s_data});
            if (s_sr) q.push_back('{is_rd: 1'b1, addr: s_addr, data: 32'h0});
            if (rand_mode)
                set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic compare();
        bit f_wr, f_rd;
        f_wr = 1'b0; f_rd = 1'b0;
        if (q.size() != 0) begin
            f_wr = !q[0].is_rd;
            f_rd = q[0].is_rd;
        end
        chk("busy",    busy,        q.size() != 0);
        chk("done",    done,        exp_done);
        chk("resp",    resp,        exp_resp);
        chk("rd_data", rd_data,     exp_rd);
        chk("awvalid", bus.awvalid, f_wr && !aw_seen);
        chk("wvalid",  bus.wvalid,  f_wr && !w_seen);
        chk("bready",  bus.bready,  f_wr && aw_seen && w_seen);
        chk("arvalid", bus.arvalid, f_rd && !ar_seen);
        chk("rready",  bus.rready,  f_rd && ar_seen);
        if (f_wr && !aw_seen) chk("awaddr", bus.awaddr, q[0].addr);
        if (f_wr && !w_seen) begin
            chk("wdata", bus.wdata, q[0].data);
            chk("wstrb", bus.wstrb, 4'hF);
        end
        if (f_rd && !ar_seen) chk("araddr", bus.araddr, q[0].addr);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (bus.awvalid) awv_cycles++;
        if (bus.wvalid)  wv_cycles++;
        if (bus.arvalid) arv_cycles++;
    endtask

    task automatic drive_slave();
        bit f_wr, f_rd;
        f_wr = (q.size() != 0) && !q[0].is_rd;
        f_rd = (q.size() != 0) && q[0].is_rd;
        if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin bus.awready = 1'b0; aw_cnt = 0; end
        if (bus.wvalid) begin bus.wready = (w_cnt >= w_dly); w_cnt++; end
        else begin bus.wready = 1'b0; w_cnt = 0; end
        if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin bus.arready = 1'b0; ar_cnt = 0; end
        if (s_b_hs) bus.bvalid = 1'b0;
        if (!bus.bvalid) begin
            if (f_wr && aw_seen && w_seen) begin
                if (b_cnt >= b_dly) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = rand_mode ? 2'($urandom_range(0, 3)) : bresp_k;
                    b_cnt = 0;
                end else b_cnt++;
            end else b_cnt = 0;
        end
        if (s_r_hs) bus.rvalid = 1'b0;
        if (!bus.rvalid) begin
            if (f_rd && ar_seen) begin
                if (r_cnt >= r_dly) begin
                    bus.rvalid = 1'b1;
                    bus.rresp  = rand_mode ? 2'($urandom_range(0, 3)) : rresp_k;
                    bus.rdata  = rand_mode ? 32'($urandom) : rdata_k;
                    r_cnt = 0;
                end else r_cnt++;
            end else r_cnt = 0;
        end
    endtask

    // One clock: sample before the edge, then update model, compare and drive at the falling edge.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        s_sw = start_write; s_sr = start_read; s_addr = addr; s_data = data;
        s_aw_hs = bus.awvalid && bus.awready;
        s_w_hs  = bus.wvalid  && bus.wready;
        s_b_hs  = bus.bvalid  && bus.bready;
        s_ar_hs = bus.arvalid && bus.arready;
        s_r_hs  = bus.rvalid  && bus.rready;
        s_awaddr = bus.awaddr; s_wdata = bus.wdata; s_wstrb = bus.wstrb; s_araddr = bus.araddr;
        s_bresp = bus.bresp; s_rresp = bus.rresp; s_rdata = bus.rdata;
        @(negedge clk);
        step_model();
        compare();
        drive_slave();
    endtask

    task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        start_write = w; start_read = r; addr = a; data = d;
        cycle();
        start_write = 1'b0; start_read = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin cycle(); n++; end
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL wait_idle: transaction still open after %0d cycles", budget);
            clear_model();
        end
    endtask

    task automatic apply_reset();
        areset_n = 1'b0;
        #1;
        clear_model();
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    endtask

    initial begin
        int d0, a0, aw0, w0, ar0;
        bool_init: begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
        end
        set_dly(0, 0, 0, 0, 0);
        bresp_k = 2'b00; rresp_k = 2'b00; rdata_k = '0;
        done_cnt = 0; ar_hs_cnt = 0; awv_cycles = 0; wv_cycles = 0; arv_cycles = 0;

        // Reset state.
        apply_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_wstrb", bus.wstrb, 4'h0);
        cycle(); cycle();
        areset_n = 1'b1;
        cycle();

        // Write to an always-ready slave: start edge N, AW/W edge N+1, B edge N+2.
        d0 = done_cnt;
        issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        wait_idle(50);
        chk("t1_awaddr", cap_awaddr, 32'h10);
        chk("t1_wdata", cap_wdata, 32'hDEADBEEF);
        chk("t1_wstrb", cap_wstrb, 4'hF);
        chk("t1_latency", done_cyc - start_cyc, 2);
        chk("t1_resp", resp, 2'b00);
        cycle(); cycle();
        chk("t1_done_count", done_cnt - d0, 1);

        // Read with arready after four visible arvalid cycles and rvalid two cycles later.
        set_dly(0, 0, 4, 0, 2);
        rdata_k = 32'h12345678;
        d0 = done_cnt; ar0 = arv_cycles;
        issue(1'b0, 1'b1, 32'h20, 32'h0);
        wait_idle(50);
        cycle(); cycle();
        chk("t2_rd_data", rd_data, 32'h12345678);
        chk("t2_araddr", cap_araddr, 32'h20);
        chk("t2_arvalid_cycles", arv_cycles - ar0, 5);
        chk("t2_done_count", done_cnt - d0, 1);

        // W completes three cycles before AW.
        set_dly(3, 0, 0, 0, 0);
        aw0 = awv_cycles; w0 = wv_cycles;
        issue(1'b1, 1'b0, 32'h24, 32'hA5A5_0001);
        wait_idle(50);
        chk("t3_wvalid_cycles", wv_cycles - w0, 1);
        chk("t3_awvalid_cycles", awv_cycles - aw0, 4);
        chk("t3_latency", done_cyc - start_cyc, 5);

        // Write and read requested together: the read follows automatically.
        set_dly(0, 0, 0, 0, 0);
        rdata_k = 32'hCAFE0030;
        d0 = done_cnt; a0 = ar_hs_cnt;
        issue(1'b1, 1'b1, 32'h30, 32'h5);
        wait_idle(100);
        cycle(); cycle();
        chk("t4_done_count", done_cnt - d0, 2);
        chk("t4_ar_count", ar_hs_cnt - a0, 1);
        chk("t4_awaddr", cap_awaddr, 32'h30);
        chk("t4_wdata", cap_wdata, 32'h5);
        chk("t4_araddr", cap_araddr, 32'h30);
        chk("t4_rd_data", rd_data, 32'hCAFE0030);

        // SLVERR write response; a start_read while waiting for B is dropped.
        set_dly(0, 0, 0, 3, 0);
        bresp_k = 2'b10;
        a0 = ar_hs_cnt;
        issue(1'b1, 1'b0, 32'h40, 32'h77);
        for (int i = 0; i < 20 && !(aw_seen && w_seen); i++) cycle();
        issue(1'b0, 1'b1, 32'h44, 32'h0);
        wait_idle(50);
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_resp", resp, 2'b10);
        chk("t5_ar_count", ar_hs_cnt - a0, 0);
        bresp_k = 2'b00;

        // Reset while waiting for R, then a fresh write.
        set_dly(0, 0, 0, 0, 20);
        issue(1'b0, 1'b1, 32'h50, 32'h0);
        for (int i = 0; i < 20 && !ar_seen; i++) cycle();
        cycle(); cycle();
        d0 = done_cnt;
        apply_reset();
        chk("t6_rready", bus.rready, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        cycle(); cycle();
        areset_n = 1'b1;
        set_dly(0, 0, 0, 0, 0);
        issue(1'b1, 1'b0, 32'h60, 32'h1234);
        wait_idle(50);
        cycle();
        chk("t6_done_count", done_cnt - d0, 1);
        chk("t6_awaddr", cap_awaddr, 32'h60);

        // Random commands, including starts while busy, against a random-latency slave.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            start_write = ($urandom_range(0, 3) == 0);
            start_read  = ($urandom_range(0, 3) == 0);
            addr = 32'($urandom);
            data = 32'($urandom);
            cycle();
        end
        start_write = 1'b0; start_read = 1'b0;
        wait_idle(200);
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
